pipeline_debug_ctrl: RTL and testbench
======================================

// Module: pipeline_debug_ctrl
// PURPOSE
//  Debug/sequencing unit sitting between a byte-stream link (UART rx/tx) and the pipeline top.
//  It loads a program into instruction memory through the pipeline write port.
//  It runs the program either continuously or one cycle at a time.
//  After each run or step it reports PC and the data word back over the link.
// PARAMETERS
//  INST_SZ      32    instruction / data word width
//  PC_SZ        32    PC width reported by pipeline
//  BYTE_SZ      8     link byte width
//  IMEM_DEPTH   256   max words loadable; the next word beyond this raises o_load_err
//  HALT_WORD    32'h0000003F  instruction that terminates a load (is itself written)
//  WDT_CYCLES   1024  RUN timeout, used only with DBG_WATCHDOG_EN
// PORTS
//  i_clk          in   1        system clock
//  i_reset        in   1        asynchronous, active-low reset
//  i_rx_data      in   BYTE_SZ  received byte
//  i_rx_valid     in   1        1-cycle strobe: i_rx_data valid
//  o_tx_data      out  BYTE_SZ  byte to transmit
//  o_tx_start     out  1        1-cycle strobe: start transmit of o_tx_data
//  i_tx_done      in   1        1-cycle strobe: transmitter finished current byte
//  o_write        out  1        pipeline instruction-memory write enable
//  o_instruction  out  INST_SZ  word to write
//  o_enable       out  1        pipeline clock-enable
//  i_pc           in   PC_SZ    pipeline PC
//  i_data         in   INST_SZ  pipeline debug data word
//  i_halt         in   1        pipeline reached HALT (level)
//  o_busy         out  1        FSM not in IDLE
//  o_load_err     out  1        sticky: load overflowed IMEM_DEPTH; cleared by next 'L'
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, word counter=0, byte counter=0.
//  Reset mid-operation aborts everything; no partial tx and no further write.
//  Commands (IDLE only): 'L'=8'h4C load, 'R'=8'h52 run, 'S'=8'h53 step, 'D'=8'h44 dump.
//  Unknown bytes in IDLE are ignored. All rx bytes are ignored in RUN/STEP/SEND.
//  States:
//   IDLE -> LOAD  on 'L': clear word counter and o_load_err.
//   LOAD: collect 4 bytes MSB first into a shift register.
//    - On the 4th byte -> WRITE.
//   WRITE: exactly one cycle.
//    - If word counter < IMEM_DEPTH: o_write=1 with o_instruction=word, and the counter increments.
//    - Otherwise no write and o_load_err=1.
//    - If word==HALT_WORD or o_load_err=1 -> IDLE; else -> LOAD.
//    - o_write is high for exactly one cycle per accepted word.
//   IDLE -> RUN on 'R'.
//    - o_enable=1 on every cycle in RUN.
//    - When i_halt is sampled 1: o_enable drops on that same cycle (combinational gate) -> SEND.
//    - If i_halt is already 1 on entry, o_enable is never asserted.
//   IDLE -> STEP on 'S'.
//    - o_enable=1 for exactly one cycle, then -> SEND.
//    - If i_halt=1, no enable pulse is given -> SEND.
//   IDLE -> SEND on 'D'; the pipeline is not enabled.
//   SEND: latch i_pc and i_data on entry.
//    - Send 8 bytes: PC[31:24]..PC[7:0], then data[31:24]..data[7:0].
//    - One o_tx_start pulse per byte, with o_tx_data stable until i_tx_done.
//    - Next byte starts the cycle after i_tx_done.
//    - After the 8th i_tx_done -> IDLE.
//  o_write and o_enable are never high in the same cycle.
//  o_busy=1 in every state except IDLE.
//  Command-to-first-effect latency: 1 cycle after the i_rx_valid strobe.
// CONFIGURATION
//  DBG_WATCHDOG_EN defined:
//   - RUN counts cycles.
//   - After WDT_CYCLES enabled cycles without i_halt: o_enable drops and -> SEND.
//   - The report is prefixed by byte 8'hEE, giving 9 bytes in total.
//  DBG_WATCHDOG_EN undefined: RUN waits for i_halt indefinitely; the counter logic is absent.
// TESTING
//  Load: 'L', then 3 words + HALT_WORD, 16 bytes
//   -> 4 o_write pulses, words in order, o_load_err=0, IDLE.
//  Overflow: IMEM_DEPTH=2, 'L' + 3 non-halt words
//   -> 2 writes, o_load_err=1, IDLE after the 3rd word.
//  Run: 'R' with i_halt rising after 5 enabled cycles
//   -> 5 o_enable cycles, then 8 tx bytes of latched i_pc/i_data MSB first.
//  Step: 'S' with i_pc=32'h4, i_data=32'h55
//   -> one o_enable cycle, tx 00 00 00 04 00 00 00 55.
//  Reset: assert i_reset low during the 3rd tx byte
//   -> all outputs 0 at once; a following 'D' sends a fresh 8-byte report.
//  Watchdog (DBG_WATCHDOG_EN, WDT_CYCLES=16): 'R', i_halt held 0
//   -> 16 o_enable cycles, then tx EE + 8 report bytes.

Source files
------------

// File: rtl/pipeline_debug_ctrl.sv
// Debug/sequencing controller between a UART byte link and the pipeline top.
// Optional RUN watchdog with 8'hEE report prefix when DBG_WATCHDOG_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a command byte ('L', 'R', 'S', 'D')
// ST_LOAD  | shifting in 4 link bytes (MSB first) of one program word
// ST_WRITE | single cycle: write the word to imem or flag overflow
// ST_RUN   | pipeline enabled until i_halt (or watchdog expiry)
// ST_STEP  | single enabled cycle unless the pipeline is halted
// ST_SEND  | streaming the latched PC/data report, one byte per tx_done
module pipeline_debug_ctrl #(
  parameter int                 INST_SZ    = 32,
  parameter int                 PC_SZ      = 32,
  parameter int                 BYTE_SZ    = 8,
  parameter int                 IMEM_DEPTH = 256,
  parameter logic [INST_SZ-1:0] HALT_WORD  = 32'h0000003F,
  parameter int                 WDT_CYCLES = 1024
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [BYTE_SZ-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_write,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_enable,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [INST_SZ-1:0] i_data,
  input  logic               i_halt,
  output logic               o_busy,
  output logic               o_load_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RUN,
    ST_STEP,
    ST_SEND
  } state_t;

  localparam int WORD_BYTES = INST_SZ / BYTE_SZ;
  localparam int REP_BYTES  = (PC_SZ + INST_SZ) / BYTE_SZ;
  localparam int REP_W      = PC_SZ + INST_SZ + BYTE_SZ;
  localparam int CNT_W      = $clog2(IMEM_DEPTH + 1);
  localparam int BC_W       = $clog2(REP_BYTES + 2);

  localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(IMEM_DEPTH);
  localparam logic [BC_W-1:0]    WORD_LAST  = BC_W'(WORD_BYTES - 1);
  localparam logic [BC_W-1:0]    REP_LAST   = BC_W'(REP_BYTES - 1);
  localparam logic [BC_W-1:0]    REP_LAST_P = BC_W'(REP_BYTES);
  localparam logic [BYTE_SZ-1:0] CMD_L      = BYTE_SZ'(8'h4C);
  localparam logic [BYTE_SZ-1:0] CMD_R      = BYTE_SZ'(8'h52);
  localparam logic [BYTE_SZ-1:0] CMD_S      = BYTE_SZ'(8'h53);
  localparam logic [BYTE_SZ-1:0] CMD_D      = BYTE_SZ'(8'h44);
  localparam logic [BYTE_SZ-1:0] WDT_MARK   = BYTE_SZ'(8'hEE);

  state_t             r_state;
  logic [INST_SZ-1:0] r_word;
  logic [BC_W-1:0]    r_byte_cnt;
  logic [BC_W-1:0]    r_last;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [REP_W-1:0]   r_rep;

  logic [INST_SZ-1:0] w_word;
  logic               w_room;
  logic               w_wdt_exp;
  logic               w_wdt_take;
  logic [REP_W-1:0]   w_rep_sel;

  assign w_word = {r_word[INST_SZ-BYTE_SZ-1:0], i_rx_data};
  assign w_room = (r_word_cnt < DEPTH_C);

`ifdef DBG_WATCHDOG_EN
  localparam int               WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_C = WDT_W'(WDT_CYCLES);

  logic [WDT_W-1:0] r_wdt_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wdt_cnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_wdt_cnt <= '0;
    end else if (o_enable) begin
      r_wdt_cnt <= r_wdt_cnt + 1'b1;
    end
  end

  assign w_wdt_exp = (r_state == ST_RUN) && (r_wdt_cnt == WDT_C);
`else
  assign w_wdt_exp = 1'b0;
`endif

  // A halt seen together with expiry is a normal stop, so it wins over the watchdog.
  assign w_wdt_take = (r_state == ST_RUN) && !i_halt && w_wdt_exp;
  assign w_rep_sel  = w_wdt_take ? {WDT_MARK, i_pc, i_data}
                                 : {i_pc, i_data, {BYTE_SZ{1'b0}}};

  // The enable is gated combinationally so a halt stops the pipeline in the cycle it appears.
  assign o_enable = ((r_state == ST_RUN)  && !i_halt && !w_wdt_exp) ||
                    ((r_state == ST_STEP) && !i_halt);
  assign o_busy   = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_word        <= '0;
      r_byte_cnt    <= '0;
      r_last        <= '0;
      r_word_cnt    <= '0;
      r_rep         <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_write       <= 1'b0;
      o_instruction <= '0;
      o_load_err    <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_write    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_L: begin
                r_state    <= ST_LOAD;
                r_word_cnt <= '0;
                r_byte_cnt <= '0;
                o_load_err <= 1'b0;
              end
              CMD_R: r_state <= ST_RUN;
              CMD_S: r_state <= ST_STEP;
              CMD_D: begin
                r_state    <= ST_SEND;
                r_byte_cnt <= '0;
                r_last     <= REP_LAST;
                r_rep      <= w_rep_sel << BYTE_SZ;
                o_tx_data  <= w_rep_sel[REP_W-1 -: BYTE_SZ];
                o_tx_start <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_LOAD: begin
          if (i_rx_valid) begin
            r_word <= w_word;
            if (r_byte_cnt == WORD_LAST) begin
              r_byte_cnt <= '0;
              r_state    <= ST_WRITE;
              if (w_room) begin
                o_write       <= 1'b1;
                o_instruction <= w_word;
                r_word_cnt    <= r_word_cnt + 1'b1;
              end else begin
                o_load_err <= 1'b1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end

        ST_WRITE: begin
          r_state <= ((r_word == HALT_WORD) || o_load_err) ? ST_IDLE : ST_LOAD;
        end

        ST_RUN, ST_STEP: begin
          if ((r_state == ST_STEP) || i_halt || w_wdt_exp) begin
            r_state    <= ST_SEND;
            r_byte_cnt <= '0;
            r_last     <= w_wdt_take ? REP_LAST_P : REP_LAST;
            r_rep      <= w_rep_sel << BYTE_SZ;
            o_tx_data  <= w_rep_sel[REP_W-1 -: BYTE_SZ];
            o_tx_start <= 1'b1;
          end
        end

        ST_SEND: begin
          if (i_tx_done) begin
            if (r_byte_cnt == r_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_rep      <= r_rep << BYTE_SZ;
              o_tx_data  <= r_rep[REP_W-1 -: BYTE_SZ];
              o_tx_start <= 1'b1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: load, overflow, run, step, dump, reset abort
// and (with DBG_WATCHDOG_EN) the RUN watchdog report.
module tb_pipeline_debug_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        rxv_b;
  logic        i_tx_done;
  logic [31:0] i_pc;
  logic [31:0] i_data;
  logic        i_halt;

  logic [7:0]  o_tx_data, b_tx_data;
  logic        o_tx_start, b_tx_start;
  logic        o_write, b_write;
  logic [31:0] o_instruction, b_instruction;
  logic        o_enable, b_enable;
  logic        o_busy, b_busy;
  logic        o_load_err, b_load_err;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int          en_cnt = 0;
  int          overlap = 0;
  int          tx_unstable = 0;
  int          wr_cnt_b = 0;
  logic [31:0] b_last = '0;

  always #5 i_clk = ~i_clk;

  pipeline_debug_ctrl #(.IMEM_DEPTH(256), .WDT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_write(o_write), .o_instruction(o_instruction), .o_enable(o_enable),
    .i_pc(i_pc), .i_data(i_data), .i_halt(i_halt),
    .o_busy(o_busy), .o_load_err(o_load_err)
  );

  pipeline_debug_ctrl #(.IMEM_DEPTH(2), .WDT_CYCLES(16)) dut_ovf (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_valid(rxv_b),
    .o_tx_data(b_tx_data), .o_tx_start(b_tx_start), .i_tx_done(i_tx_done),
    .o_write(b_write), .o_instruction(b_instruction), .o_enable(b_enable),
    .i_pc(i_pc), .i_data(i_data), .i_halt(i_halt),
    .o_busy(b_busy), .o_load_err(b_load_err)
  );

  always @(negedge i_clk) begin
    if (o_write) wr_q.push_back(o_instruction);
    if (o_enable) en_cnt++;
    if (o_write && o_enable) overlap++;
    if (b_write) begin
      wr_cnt_b++;
      b_last = b_instruction;
    end
  end

  // Transmitter model: captures each started byte and answers with tx_done two cycles later.
  initial begin
    logic [7:0] cur;
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      while (o_tx_start) begin
        cur = o_tx_data;
        tx_q.push_back(cur);
        repeat (2) begin
          @(negedge i_clk);
          if (i_reset && (o_tx_data != cur)) tx_unstable++;
        end
        @(posedge i_clk); #1;
        i_tx_done = 1'b1;
        @(posedge i_clk); #1;
        i_tx_done = 1'b0;
        @(negedge i_clk);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit to_b);
    i_rx_data = b;
    if (to_b) rxv_b = 1'b1;
    else      i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    rxv_b = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit to_b);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], to_b);
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, " idle"}, o_busy, 1'b0);
  endtask

  task automatic check_report(input string tag, input logic [31:0] pc, input logic [31:0] dat,
                              input bit pfx);
    logic [63:0] rep;
    int off;
    rep = {pc, dat};
    off = pfx ? 1 : 0;
    check({tag, " nbytes"}, tx_q.size(), 8 + off);
    if (pfx && tx_q.size() > 0) check({tag, " prefix"}, tx_q[0], 8'hEE);
    for (int i = 0; i < 8; i++)
      if (i + off < tx_q.size())
        check($sformatf("%s byte%0d", tag, i), tx_q[i + off], rep[63 - 8*i -: 8]);
  endtask

  task automatic run_n(input string tag, input int n, input logic [31:0] pc,
                       input logic [31:0] dat);
    i_pc = pc;
    i_data = dat;
    i_halt = 1'b0;
    en_cnt = 0;
    tx_q.delete();
    send_byte(8'h52, 1'b0);
    @(negedge i_clk);
    check({tag, " latency"}, o_enable, 1'b1);
    repeat (n) tick();
    i_halt = 1'b1;
    wait_idle(tag, 200);
    i_halt = 1'b0;
    check({tag, " enables"}, en_cnt, n);
    check_report(tag, pc, dat, 1'b0);
  endtask

  initial begin
    logic [31:0] words[4];
    int guard;
    words[0] = 32'h11223344;
    words[1] = 32'hA5A50001;
    words[2] = 32'hDEADBEEF;
    words[3] = 32'h0000003F;

    i_reset = 1'b0;
    i_rx_data = '0;
    i_rx_valid = 1'b0;
    rxv_b = 1'b0;
    i_pc = '0;
    i_data = '0;
    i_halt = 1'b0;
    repeat (3) tick();
    check("reset busy", o_busy, 1'b0);
    check("reset outs", {o_tx_start, o_write, o_enable, o_load_err, o_tx_data}, '0);
    check("reset instr", o_instruction, 32'h0);
    i_reset = 1'b1;
    tick();

    // Program load terminated by the halt word.
    send_byte(8'h4C, 1'b0);
    check("load busy", o_busy, 1'b1);
    for (int i = 0; i < 4; i++) send_word(words[i], 1'b0);
    wait_idle("load", 10);
    check("load nwrites", wr_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wr_q.size()) check($sformatf("load word%0d", i), wr_q[i], words[i]);
    check("load err", o_load_err, 1'b0);

    // Overflow on the 2-deep instance.
    send_byte(8'h4C, 1'b1);
    send_word(32'h01020304, 1'b1);
    send_word(32'h05060708, 1'b1);
    send_word(32'h090A0B0C, 1'b1);
    check("ovf idle", b_busy, 1'b0);
    check("ovf nwrites", wr_cnt_b, 2);
    check("ovf last word", b_last, 32'h05060708);
    check("ovf err", b_load_err, 1'b1);
    send_byte(8'h4C, 1'b1);
    check("ovf err clear", b_load_err, 1'b0);

    // Unknown command is ignored.
    send_byte(8'h58, 1'b0);
    check("unknown idle", o_busy, 1'b0);

    run_n("run5", 5, 32'h00001234, 32'hCAFEF00D);
`ifndef DBG_WATCHDOG_EN
    run_n("run20", 20, 32'h00000040, 32'h12345678);
`endif

    // Single step.
    i_pc = 32'h4;
    i_data = 32'h55;
    en_cnt = 0;
    tx_q.delete();
    send_byte(8'h53, 1'b0);
    wait_idle("step", 100);
    check("step enables", en_cnt, 1);
    check_report("step", 32'h4, 32'h55, 1'b0);

    // Step while halted gives no enable pulse.
    i_halt = 1'b1;
    i_pc = 32'h8;
    i_data = 32'h66;
    en_cnt = 0;
    tx_q.delete();
    send_byte(8'h53, 1'b0);
    wait_idle("hstep", 100);
    i_halt = 1'b0;
    check("hstep enables", en_cnt, 0);
    check_report("hstep", 32'h8, 32'h66, 1'b0);

    // Reset during the third report byte, then a fresh dump.
    i_pc = 32'h89ABCDEF;
    i_data = 32'h01234567;
    tx_q.delete();
    send_byte(8'h44, 1'b0);
    guard = 0;
    while (tx_q.size() < 3 && guard < 100) begin
      tick();
      guard++;
    end
    check("rst third byte", tx_q.size(), 3);
    i_reset = 1'b0;
    #1;
    check("rst outs", {o_busy, o_tx_start, o_write, o_enable, o_load_err, o_tx_data}, '0);
    check("rst instr", o_instruction, 32'h0);
    repeat (3) tick();
    i_reset = 1'b1;
    repeat (6) tick();
    tx_q.delete();
    en_cnt = 0;
    i_pc = 32'h0BADF00D;
    i_data = 32'h600DCAFE;
    send_byte(8'h44, 1'b0);
    wait_idle("dump", 100);
    check("dump enables", en_cnt, 0);
    check_report("dump", 32'h0BADF00D, 32'h600DCAFE, 1'b0);
    check("no stray write", wr_q.size(), 4);

`ifdef DBG_WATCHDOG_EN
    i_pc = 32'h00000100;
    i_data = 32'h0000BEEF;
    i_halt = 1'b0;
    en_cnt = 0;
    tx_q.delete();
    send_byte(8'h52, 1'b0);
    wait_idle("wdt", 300);
    check("wdt enables", en_cnt, 16);
    check_report("wdt", 32'h00000100, 32'h0000BEEF, 1'b1);
`endif

    check("write/enable overlap", overlap, 0);
    check("tx data stable", tx_unstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
